// File: rtl/mips_pkg.sv
// Shared constants and types for the register-file write path.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {CLEAR, RUN} rf_wr_state_t;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves only on accepted grants.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // last_grant = 1 means requester 1 won most recently; reset value favours requester 0
    logic last_grant;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = last_grant ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant <= 1'b1;
        end else if (i_accept) begin
            last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port sequencer: clears all registers after reset, then
// round-robin shares the single write port between two writeback requesters.
module rf_write_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_data,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req1_ready,
    output logic [ADDR_W-1:0] o_A3,
    output logic [DATA_W-1:0] o_WD3,
    output logic              o_WE3,
    output logic              o_clear_done,
    output rf_wr_state_t      o_state
);

    // Handshake: a write transfers in any cycle where reqN_valid && reqN_ready;
    // ready is combinational from valids, state and pointer (never from itself),
    // and the requester holds addr/data until it sees ready.

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    rf_wr_state_t      state;
    rf_wr_state_t      state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [1:0]        grant;
    logic              arb_en;
    logic              accept;

    assign o_state = state;

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == LAST_ADDR) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // The first RUN cycle still presents the final clear write, so grants wait for clear_done.
    assign arb_en = (state == RUN) && o_clear_done;
    assign accept = |grant;

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (arb_en),
        .i_req    ({i_req1_valid, i_req0_valid}),
        .i_accept (accept),
        .o_grant  (grant)
    );

    assign o_req0_ready = grant[0];
    assign o_req1_ready = grant[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clr_cnt      <= '0;
            o_WE3        <= 1'b0;
            o_A3         <= '0;
            o_WD3        <= '0;
            o_clear_done <= 1'b0;
        end else begin
            o_clear_done <= (state == RUN);
            if (state == CLEAR) begin
                o_WE3   <= 1'b1;
                o_A3    <= clr_cnt;
                o_WD3   <= '0;
                clr_cnt <= clr_cnt + 1'b1;
            end else if (grant[0]) begin
                // $zero writes are accepted but never enabled
                o_WE3 <= (i_req0_addr != '0);
                o_A3  <= i_req0_addr;
                o_WD3 <= i_req0_data;
            end else if (grant[1]) begin
                o_WE3 <= (i_req1_addr != '0);
                o_A3  <= i_req1_addr;
                o_WD3 <= i_req1_data;
            end else begin
                o_WE3 <= 1'b0;
            end
        end
    end

endmodule
